// File: rtl/qerv_lsu_bufreg.sv
// qerv bit-serial buffer register: serial operand fill, aligned 32-bit bus access
// with load extension, serial drain of load data, and shift-amount down-counting.
module qerv_lsu_bufreg #(
    parameter int W  = 4,
    parameter int LB = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    input  logic [1:0]    i_lsb,
    input  logic [W-1:0]  i_dat_s,
    output logic [W-1:0]  o_dat_s,
    output logic          o_valid_s,
    output logic          o_cyc,
    output logic          o_we,
    output logic [3:0]    o_sel,
    output logic [31:0]   o_dat,
    input  logic [31:0]   i_rdt,
    input  logic          i_ack,
    output logic          o_busy,
    output logic [LB:0]   o_shift_lsb,
    output logic          o_sh_done,
    output logic          o_done,
    output logic          o_err
);

    localparam int BW = 5 - LB;
    localparam logic [BW-1:0] LAST_BEAT = '1;
    localparam logic [4:0] REM_MASK = 5'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BUS,
        S_DRAIN,
        S_COUNT
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    dat_q, dat_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [BW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [1:0]     size_q, size_d;
    logic [1:0]     lsb_q, lsb_d;
    logic           sgn_q, sgn_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           last_beat;
    logic           is_store;
    logic           is_count;
    logic           misaligned;
    logic [4:0]     shamt_rem;

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            default: bad = (lsb != 2'd0);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            2'd0:    sel = 4'b0001 << lsb;
            2'd1:    sel = 4'b0011 << lsb;
            default: sel = 4'hF;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] rdt, input logic [1:0] lsb,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] x;
        logic [31:0] r;
        x = rdt >> {lsb, 3'b000};
        case (size)
            2'd0:    r = {{24{sgn & x[7]}}, x[7:0]};
            2'd1:    r = {{16{sgn & x[15]}}, x[15:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    // op 2 and the reserved op 3 both run the shift counter
    assign is_store   = (op_q == 2'd0);
    assign is_count   = op_q[1];
    assign last_beat  = (beat_q == LAST_BEAT);
    assign misaligned = addr_misaligned(size_q, lsb_q);
    assign shamt_rem  = dat_q[31:27] & REM_MASK;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_FILL;
            end
            S_FILL: begin
                if (last_beat) begin
                    if (is_count)        state_d = S_COUNT;
                    else if (misaligned) state_d = S_IDLE;
                    else                 state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (i_ack) state_d = is_store ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (last_beat) state_d = S_IDLE;
            end
            S_COUNT: begin
                if (cnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dat_q  <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            size_q <= '0;
            lsb_q  <= '0;
            sgn_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            size_q <= size_d;
            lsb_q  <= lsb_d;
            sgn_q  <= sgn_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        dat_d  = dat_q;
        beat_d = beat_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        size_d = size_q;
        lsb_d  = lsb_q;
        sgn_d  = sgn_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (i_start) begin
                    op_d   = i_op;
                    size_d = i_size;
                    lsb_d  = i_lsb;
                    sgn_d  = i_signed;
                end
            end
            S_FILL: begin
                dat_d  = {i_dat_s, dat_q[31:W]};
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    // counter preloads from the word being completed this cycle
                    cnt_d = dat_d[31:27+LB];
                    if (!is_count && misaligned) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (i_ack) begin
                    if (is_store) done_d = 1'b1;
                    else          dat_d  = load_ext(i_rdt, lsb_q, size_q, sgn_q);
                end
            end
            S_DRAIN: begin
                dat_d  = {{W{1'b0}}, dat_q[31:W]};
                beat_d = beat_q + 1'b1;
                if (last_beat) done_d = 1'b1;
            end
            S_COUNT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_cyc       = 1'b0;
        o_we        = 1'b0;
        o_sel       = 4'h0;
        o_valid_s   = 1'b0;
        o_dat_s     = '0;
        o_shift_lsb = '0;
        o_sh_done   = 1'b0;
        o_busy      = (state_q != S_IDLE);
        o_done      = done_q;
        o_err       = err_q;
        o_dat       = dat_q << {lsb_q, 3'b000};
        case (state_q)
            S_BUS: begin
                o_cyc = 1'b1;
                o_we  = is_store;
                o_sel = byte_sel(size_q, lsb_q);
            end
            S_DRAIN: begin
                o_valid_s = 1'b1;
                o_dat_s   = dat_q[W-1:0];
            end
            S_COUNT: begin
                o_shift_lsb = shamt_rem[LB:0];
                o_sh_done   = (cnt_q == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qerv_lsu_bufreg.sv
// Directed bench for qerv_lsu_bufreg at W=4, W=8 and W=1 with a queue of
// expected bus words, load results and shift-count lengths.
module tb_qerv_lsu_bufreg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  op, size, lsb;
    logic        sgn;
    logic [31:0] rdt;
    logic        ack;
    logic        start4, start8, start1;
    logic [3:0]  d4;
    logic [7:0]  d8;
    logic [0:0]  d1;

    logic [3:0]  ds4;  logic vld4, cyc4, we4, busy4, shd4, done4, err4;
    logic [3:0]  sel4; logic [31:0] dat4; logic [2:0] shl4;
    logic [7:0]  ds8;  logic vld8, cyc8, we8, busy8, shd8, done8, err8;
    logic [3:0]  sel8; logic [31:0] dat8; logic [3:0] shl8;
    logic [0:0]  ds1;  logic vld1, cyc1, we1, busy1, shd1, done1, err1;
    logic [3:0]  sel1; logic [31:0] dat1; logic [0:0] shl1;

    qerv_lsu_bufreg #(.W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_op(op), .i_size(size),
        .i_signed(sgn), .i_lsb(lsb), .i_dat_s(d4), .o_dat_s(ds4), .o_valid_s(vld4),
        .o_cyc(cyc4), .o_we(we4), .o_sel(sel4), .o_dat(dat4), .i_rdt(rdt), .i_ack(ack),
        .o_busy(busy4), .o_shift_lsb(shl4), .o_sh_done(shd4), .o_done(done4), .o_err(err4));

    qerv_lsu_bufreg #(.W(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_op(op), .i_size(size),
        .i_signed(sgn), .i_lsb(lsb), .i_dat_s(d8), .o_dat_s(ds8), .o_valid_s(vld8),
        .o_cyc(cyc8), .o_we(we8), .o_sel(sel8), .o_dat(dat8), .i_rdt(rdt), .i_ack(ack),
        .o_busy(busy8), .o_shift_lsb(shl8), .o_sh_done(shd8), .o_done(done8), .o_err(err8));

    qerv_lsu_bufreg #(.W(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_op(op), .i_size(size),
        .i_signed(sgn), .i_lsb(lsb), .i_dat_s(d1), .o_dat_s(ds1), .o_valid_s(vld1),
        .o_cyc(cyc1), .o_we(we1), .o_sel(sel1), .o_dat(dat1), .i_rdt(rdt), .i_ack(ack),
        .o_busy(busy1), .o_shift_lsb(shl1), .o_sh_done(shd1), .o_done(done1), .o_err(err1));

    int cur_w;
    logic [31:0] s_ds, s_vld, s_cyc, s_we, s_sel, s_dat, s_busy, s_shl, s_shd, s_done, s_err;

    always_comb begin
        s_ds = 32'(ds4);  s_vld = 32'(vld4);   s_cyc = 32'(cyc4);   s_we = 32'(we4);
        s_sel = 32'(sel4); s_dat = dat4;       s_busy = 32'(busy4); s_shl = 32'(shl4);
        s_shd = 32'(shd4); s_done = 32'(done4); s_err = 32'(err4);
        if (cur_w == 8) begin
            s_ds = 32'(ds8);  s_vld = 32'(vld8);   s_cyc = 32'(cyc8);   s_we = 32'(we8);
            s_sel = 32'(sel8); s_dat = dat8;       s_busy = 32'(busy8); s_shl = 32'(shl8);
            s_shd = 32'(shd8); s_done = 32'(done8); s_err = 32'(err8);
        end else if (cur_w == 1) begin
            s_ds = 32'(ds1);  s_vld = 32'(vld1);   s_cyc = 32'(cyc1);   s_we = 32'(we1);
            s_sel = 32'(sel1); s_dat = dat1;       s_busy = 32'(busy1); s_shl = 32'(shl1);
            s_shd = 32'(shd1); s_done = 32'(done1); s_err = 32'(err1);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        start4 = v && (cur_w == 4);
        start8 = v && (cur_w == 8);
        start1 = v && (cur_w == 1);
    endtask

    task automatic start_op(input int w, input logic [1:0] o, input logic [1:0] sz,
                            input logic [1:0] l, input logic s);
        @(negedge clk);
        cur_w = w; op = o; size = sz; lsb = l; sgn = s;
        set_start(1'b1);
    endtask

    task automatic fill(input logic [31:0] v, input int pulse_at);
        int n;
        n = 32 / cur_w;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            set_start(k == pulse_at);
            if (cur_w == 4)      d4 = v[4*k +: 4];
            else if (cur_w == 8) d8 = v[8*k +: 8];
            else                 d1 = v[k +: 1];
            check("fill_busy", s_busy, 32'd1);
            check("fill_cyc", s_cyc, 32'd0);
        end
    endtask

    task automatic drain();
        logic [31:0] exp, got, mask;
        int n;
        n = 32 / cur_w;
        mask = (32'd1 << cur_w) - 32'd1;
        exp = exp_q.pop_front();
        got = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ack = 1'b0;
            check("drain_vld", s_vld, 32'd1);
            check("drain_beat", s_ds, (exp >> (k * cur_w)) & mask);
            got = got | (s_ds << (k * cur_w));
        end
        check("drain_word", got, exp);
        @(negedge clk);
        check("drain_done", s_done, 32'd1);
        check("drain_vld_off", s_vld, 32'd0);
        check("drain_idle", s_busy, 32'd0);
    endtask

    task automatic count_phase();
        logic [31:0] exp_len, exp_lsb;
        int n;
        exp_len = exp_q.pop_front();
        exp_lsb = exp_q.pop_front();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("count_lsb", s_shl, exp_lsb);
        end while (s_shd !== 32'd1 && n < 40);
        check("count_len", 32'(n), exp_len);
        @(negedge clk);
        check("count_done", s_done, 32'd1);
        check("count_shd_off", s_shd, 32'd0);
        check("count_err", s_err, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; op = '0; size = '0; lsb = '0; sgn = 1'b0; rdt = '0; ack = 1'b0;
        start4 = 1'b0; start8 = 1'b0; start1 = 1'b0; d4 = '0; d8 = '0; d1 = '0; cur_w = 4;
        repeat (2) @(negedge clk);
        check("rst_busy", s_busy, 32'd0);
        check("rst_cyc", s_cyc, 32'd0);
        check("rst_sel", s_sel, 32'd0);
        check("rst_dat", s_dat, 32'd0);
        check("rst_done", s_done, 32'd0);
        check("rst_err", s_err, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // W=4 store byte at lane 2, stray start pulse mid-fill, ack on third bus cycle
        start_op(4, 2'd0, 2'd0, 2'd2, 1'b0);
        exp_q.push_back(32'h00A5_0000);
        fill(32'h0000_00A5, 3);
        @(negedge clk);
        check("st_cyc", s_cyc, 32'd1);
        check("st_we", s_we, 32'd1);
        check("st_sel", s_sel, 32'h4);
        check("st_dat", s_dat, exp_q[0]);
        @(negedge clk);
        check("st_cyc_hold", s_cyc, 32'd1);
        check("st_dat_hold", s_dat, exp_q.pop_front());
        @(negedge clk);
        check("st_cyc_hold2", s_cyc, 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("st_cyc_off", s_cyc, 32'd0);
        check("st_done", s_done, 32'd1);
        check("st_err", s_err, 32'd0);
        @(negedge clk);
        check("st_done_pulse", s_done, 32'd0);

        // W=4 signed byte load at lane 1
        start_op(4, 2'd1, 2'd0, 2'd1, 1'b1);
        exp_q.push_back(32'hFFFF_FF80);
        fill(32'h1234_5678, -1);
        @(negedge clk);
        check("ldb_cyc", s_cyc, 32'd1);
        check("ldb_we", s_we, 32'd0);
        check("ldb_sel", s_sel, 32'h2);
        rdt = 32'h0000_8000; ack = 1'b1;
        drain();

        // W=4 unsigned half load at lane 2
        start_op(4, 2'd1, 2'd1, 2'd2, 1'b0);
        exp_q.push_back(32'h0000_BEEF);
        fill(32'h0, -1);
        @(negedge clk);
        check("ldh_sel", s_sel, 32'hC);
        rdt = 32'hBEEF_1234; ack = 1'b1;
        drain();

        // W=4 shift count 13, then 0 via the reserved op
        start_op(4, 2'd2, 2'd0, 2'd0, 1'b0);
        exp_q.push_back(32'd4); exp_q.push_back(32'd1);
        fill(32'd13 << 27, -1);
        count_phase();
        start_op(4, 2'd3, 2'd0, 2'd0, 1'b0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        fill(32'h07FF_FFFF, -1);
        count_phase();

        // W=1 shift count 31
        start_op(1, 2'd2, 2'd0, 2'd0, 1'b0);
        exp_q.push_back(32'd32); exp_q.push_back(32'd0);
        fill(32'd31 << 27, -1);
        count_phase();

        // W=8 misaligned word store, then aligned word load
        start_op(8, 2'd0, 2'd2, 2'd1, 1'b0);
        fill(32'hDEAD_BEEF, -1);
        @(negedge clk);
        check("mis_done", s_done, 32'd1);
        check("mis_err", s_err, 32'd1);
        check("mis_cyc", s_cyc, 32'd0);
        check("mis_busy", s_busy, 32'd0);
        @(negedge clk);
        check("mis_err_pulse", s_err, 32'd0);
        start_op(8, 2'd1, 2'd2, 2'd0, 1'b1);
        exp_q.push_back(32'h8765_4321);
        fill(32'h0, -1);
        @(negedge clk);
        check("ldw_sel", s_sel, 32'hF);
        rdt = 32'h8765_4321; ack = 1'b1;
        drain();

        // W=4 reset while the bus cycle waits, then a clean half store
        start_op(4, 2'd0, 2'd2, 2'd0, 1'b0);
        fill(32'h1122_3344, -1);
        @(negedge clk);
        check("rb_cyc_on", s_cyc, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_cyc_off", s_cyc, 32'd0);
        check("rb_busy_off", s_busy, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(4, 2'd0, 2'd1, 2'd2, 1'b0);
        exp_q.push_back(32'hCAFE_0000);
        fill(32'h0000_CAFE, -1);
        @(negedge clk);
        check("rh_sel", s_sel, 32'hC);
        check("rh_dat", s_dat, exp_q.pop_front());
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("rh_done", s_done, 32'd1);
        check("rh_cyc_off", s_cyc, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qerv_lsu_bufreg.md
Name: qerv_lsu_bufreg

Overview:
Parametrised W-bit-serial buffer register for the qerv datapath, combining store, load and shift-count functions under an explicit state machine.
- Serialises operand data in, drives an aligned 32-bit bus cycle with byte selects, and captures sign/zero-extended load data.
- Serialises load data back out, W bits per cycle, LSB first.
- Runs a shift-amount down-counter with remainder reporting for shifts not divisible by W.

Parameters:
W, 4, serial datapath width in bits; legal values 1, 2, 4, 8.
LB, $clog2(W), derived; width of the shift-remainder output minus one. Do not override.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  begin operation; sampled in IDLE only
i_op  in  2  0=store, 1=load, 2=shift-count, 3=reserved (treated as shift-count)
i_size  in  2  0=byte, 1=half, 2/3=word
i_signed  in  1  sign-extend load data
i_lsb  in  2  address bits [1:0]
i_dat_s  in  W  serial data in, LSB first (store data / shamt)
o_dat_s  out  W  serial load data out, LSB first
o_valid_s  out  1  o_dat_s valid (DRAIN state)
o_cyc  out  1  bus request
o_we  out  1  bus write
o_sel  out  4  byte lane enables
o_dat  out  32  bus write data, lane-aligned
i_rdt  in  32  bus read data
i_ack  in  1  bus acknowledge
o_busy  out  1  state != IDLE
o_shift_lsb  out  LB+1  shamt mod W; valid during COUNT, bit LB always 0
o_sh_done  out  1  last COUNT cycle
o_done  out  1  one-cycle completion pulse
o_err  out  1  misaligned access; valid with o_done

Behaviour:
- Reset, asynchronous:
  - state=IDLE, data register and counters = 0.
  - All outputs 0.
  - Reset asserted mid-operation aborts immediately; o_cyc drops in the same reset assertion.
- States: IDLE, FILL, BUS, DRAIN, COUNT.
- IDLE:
  - On i_start, latch i_op, i_size, i_signed, i_lsb and go to FILL.
  - i_start outside IDLE is ignored.
- FILL:
  - Lasts exactly 32/W cycles.
  - Each cycle: dat <= {i_dat_s, dat[31:W]}.
  - The 5-LB-bit beat counter wraps to 0 on the last beat.
  - On the last beat:
    - store/load misaligned (half with i_lsb[0]=1, or word with i_lsb!=0): go to IDLE with o_done=o_err=1 next cycle; no bus cycle.
    - store/load aligned: go to BUS.
    - shift-count: go to COUNT.
- BUS:
  - o_cyc=1; o_we=1 for store.
  - o_sel: byte = 1<<lsb; half = 2'b11<<lsb; word = 4'hF.
  - o_dat = dat << (8*lsb); stays stable until i_ack.
  - Wait indefinitely for i_ack.
  - Store + i_ack: o_cyc=0 next cycle, state IDLE, o_done pulse in that cycle.
  - Load + i_ack: capture x = i_rdt >> (8*lsb). Byte: x[7:0] extended with x[7] if i_signed, else 0. Half: x[15:0], same rule with x[15]. Word: x. Go to DRAIN.
  - i_ack outside BUS is ignored.
- DRAIN:
  - 32/W cycles; o_valid_s=1 and o_dat_s=dat[W-1:0].
  - Each cycle: dat <= {W'b0, dat[31:W]}.
  - After the last beat: IDLE with o_done pulse.
- COUNT:
  - shamt = dat[31:27] (the last 5 bits shifted in).
  - Counter c loaded with shamt>>LB on COUNT entry (combinational from dat at FILL end).
  - o_shift_lsb = shamt & (W-1), held for all of COUNT.
  - Each cycle c decrements.
  - o_sh_done=1 in the cycle c==0; next cycle IDLE with o_done pulse.
  - COUNT duration = (shamt>>LB)+1 cycles; shamt=0 gives 1 cycle.
  - For W=1, o_shift_lsb is always 0.
- Outputs not listed for a state are 0.
- o_dat holds the last driven value outside BUS; it is don't-care there.
- o_err is 0 except in a misaligned done pulse.

Test Plan:
- W=4, store byte, i_lsb=2, serial 0x000000A5 → after 8 FILL cycles o_cyc=1, o_we=1, o_sel=4'b0100, o_dat[23:16]=8'hA5; ack in cycle 3 → o_cyc=0 and o_done=1 the next cycle.
- W=4, load signed byte, i_lsb=1, i_rdt=0x00008000 → o_dat_s sequence over 8 beats = 0,8,F,F,F,F,F,F (0xFFFFFF80), then o_done.
- W=4, load unsigned half, i_lsb=2, i_rdt=0xBEEF1234 → drained value 0x0000BEEF; o_sel=4'b1100.
- W=4, shift-count shamt=13 → o_shift_lsb=1; COUNT lasts 4 cycles; o_sh_done only on the 4th; o_done the following cycle. Repeat with shamt=0 → 1 COUNT cycle. Repeat with W=1, shamt=31 → 32 COUNT cycles.
- W=8, word store with i_lsb=1 → o_cyc never asserts; o_done=o_err=1 one cycle after the 4th FILL beat.
- Reset asserted during BUS (no ack) → o_cyc, o_busy=0 immediately; after release an i_start completes normally. i_start pulsed during FILL → no effect on the beat count.
